// File: rtl/dma_ref_pkg.sv
// Shared definitions for the OAM sprite-DMA master.
//   dma_state_t        : DMA sequencer states
//   OAM_DATA_ADDR_DEF  : PPU OAM data port every DMA byte is written to
//   OAM_XFER_LEN_DEF   : bytes copied per DMA transfer
package dma_ref_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
    localparam int          OAM_XFER_LEN_DEF  = 256;

endpackage

// File: rtl/oam_dma_master_if.sv
// cpu_ref memory bus: one address, write data, write enable, and read data
// returned combinationally by the memory in the same cycle.
//   master : drives addr_out/data_out/wen, receives data_in
//   slave  : memory side
interface oam_dma_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              wen;
    logic [DATA_W-1:0] data_in;

    modport master (output addr_out, output data_out, output wen, input data_in);
    modport slave  (input addr_out, input data_out, input wen, output data_in);
endinterface

// File: rtl/oam_dma_master.sv
// NES sprite DMA bus master. A trigger pulse (CPU write to $4014) halts the
// CPU via stall and copies XFER_LEN bytes from {page,8'h00} to the OAM data
// port as read/write pairs, with one dummy cycle plus one alignment cycle
// when the halt lands on an odd CPU cycle.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   trigger, page  : start pulse and source page (sampled together)
//   cpu_cycle_odd  : current CPU cycle parity
//   stall          : CPU halt / bus grant
//   done           : one-cycle pulse after the final write
//   bus            : cpu_ref memory bus (master side)
//   xfer_count, ignored_count : only with OAM_DMA_STATS_EN defined
module oam_dma_master
    import dma_ref_pkg::*;
#(
    parameter int              ADDR_W        = 16,
    parameter int              DATA_W        = 8,
    parameter logic [15:0]     OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
    parameter int              XFER_LEN      = OAM_XFER_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic [7:0]         page,
    input  logic               cpu_cycle_odd,
    output logic               stall,
    output logic               done,
`ifdef OAM_DMA_STATS_EN
    output logic [15:0]        xfer_count,
    output logic [7:0]         ignored_count,
`endif
    oam_dma_master_if.master   bus
);

    localparam int IDX_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    dma_state_t        state;
    logic [7:0]        page_q;
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  index_nxt;
    logic [DATA_W-1:0] latch;
    logic              last_byte;

    // Index is kept at its own width so it wraps instead of carrying into the page byte.
    assign index_nxt = index + 1'b1;
    assign last_byte = (index == LAST_IDX);

    function automatic logic [ADDR_W-1:0] src_addr(input logic [7:0] pg, input logic [IDX_W-1:0] idx);
        return ADDR_W'({pg, 8'(idx)});
    endfunction

    // Write data only leaves the block during WRITE, where wen is the registered qualifier.
    assign bus.data_out = bus.wen ? latch : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            page_q       <= '0;
            index        <= '0;
            latch        <= '0;
            stall        <= 1'b0;
            done         <= 1'b0;
            bus.wen      <= 1'b0;
            bus.addr_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page_q <= page;
                        index  <= '0;
                        stall  <= 1'b1;
                        state  <= HALT;
                    end
                end
                HALT: begin
                    if (cpu_cycle_odd) begin
                        state <= ALIGN;
                    end else begin
                        state        <= READ;
                        bus.addr_out <= src_addr(page_q, index);
                    end
                end
                ALIGN: begin
                    state        <= READ;
                    bus.addr_out <= src_addr(page_q, index);
                end
                READ: begin
                    latch        <= bus.data_in;
                    bus.wen      <= 1'b1;
                    bus.addr_out <= ADDR_W'(OAM_DATA_ADDR);
                    state        <= WRITE;
                end
                WRITE: begin
                    bus.wen <= 1'b0;
                    if (last_byte) begin
                        stall        <= 1'b0;
                        done         <= 1'b1;
                        bus.addr_out <= '0;
                        state        <= IDLE;
                    end else begin
                        index        <= index_nxt;
                        bus.addr_out <= src_addr(page_q, index_nxt);
                        state        <= READ;
                    end
                end
                default: begin
                    stall        <= 1'b0;
                    bus.wen      <= 1'b0;
                    bus.addr_out <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef OAM_DMA_STATS_EN
    // xfer_count steps on the same edge that raises done, so it is current while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count    <= '0;
            ignored_count <= '0;
        end else begin
            if (state == WRITE && last_byte)
                xfer_count <= xfer_count + 1'b1;
            if (trigger && state != IDLE && ignored_count != 8'hFF)
                ignored_count <= ignored_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_oam_dma_master.sv
// Self-checking bench for oam_dma_master: a 64 KiB memory responder on the
// cpu_ref bus, a negedge bus monitor, and an expected-transfer model built
// from the source page contents.
module tb_oam_dma_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trigger = 1'b0;
    logic       cpu_cycle_odd = 1'b0;
    logic [7:0] page = 8'h00;
    logic       stall, done;
`ifdef OAM_DMA_STATS_EN
    logic [15:0] xfer_count;
    logic [7:0]  ignored_count;
`endif

    oam_dma_master_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    oam_dma_master dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trigger       (trigger),
        .page          (page),
        .cpu_cycle_odd (cpu_cycle_odd),
        .stall         (stall),
        .done          (done),
`ifdef OAM_DMA_STATS_EN
        .xfer_count    (xfer_count),
        .ignored_count (ignored_count),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Memory responder: combinational read, posedge write.
    logic [7:0] mem [0:65535];
    assign bus.data_in = mem[bus.addr_out];
    always @(posedge clk) if (bus.wen) mem[bus.addr_out] <= bus.data_out;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled mid-cycle.
    int cyc = 0, stall_cnt, first_stall, first_rd, last_wr, done_cyc, done_cnt, zero_cyc;
    logic [7:0]  wr_q [$];
    logic [15:0] wa_q [$];
    logic [15:0] rd_q [$];

    task automatic clear_mon();
        stall_cnt = 0; first_stall = -1; first_rd = -1; last_wr = -1;
        done_cyc = -1; done_cnt = 0; zero_cyc = 0;
        wr_q.delete(); wa_q.delete(); rd_q.delete();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (stall) begin
            stall_cnt++;
            if (first_stall < 0) first_stall = cyc;
        end
        if (bus.wen) begin
            wr_q.push_back(bus.data_out);
            wa_q.push_back(bus.addr_out);
            last_wr = cyc;
        end else if (stall) begin
            if (bus.addr_out == 16'h0000) zero_cyc++;
            else begin
                rd_q.push_back(bus.addr_out);
                if (first_rd < 0) first_rd = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic start_xfer(input logic [7:0] pg, input logic odd);
        @(posedge clk);
        #1;
        clear_mon();
        cpu_cycle_odd = odd;
        trigger = 1'b1;
        page = pg;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        #1;
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_writes(input int n);
        bit ok = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            #1;
            if (wr_q.size() >= n) begin ok = 1; break; end
        end
        if (!ok) chk("write_timeout", 0, 1);
    endtask

    // Expected transfer: byte i of the page goes to the OAM port, in order.
    task automatic check_xfer(input string tag, input logic [7:0] pg, input logic odd);
        int bad_wa = 0, bad_rd = 0;
        logic [15:0] a;
        chk({tag, "_stall_cycles"}, stall_cnt, 32'(513 + int'(odd)));
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_nwrites"}, wr_q.size(), 256);
        chk({tag, "_nreads"}, rd_q.size(), 256);
        chk({tag, "_read_latency"}, first_rd - first_stall, 32'(1 + int'(odd)));
        chk({tag, "_done_after_last"}, done_cyc - last_wr, 1);
        chk({tag, "_dummy_cycles"}, zero_cyc, 32'(1 + int'(odd)));
        if (wr_q.size() == 256 && rd_q.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                a = {pg, 8'(i)};
                chk({tag, "_wdata"}, wr_q[i], mem[a]);
                if (wa_q[i] != 16'h2004) bad_wa++;
                if (rd_q[i] != a) bad_rd++;
            end
            chk({tag, "_bad_waddr"}, bad_wa, 0);
            chk({tag, "_bad_raddr"}, bad_rd, 0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pg;
        logic       odd;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        clear_mon();

        // Reset state
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_wen", bus.wen, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", bus.addr_out, 0);
        chk("rst_wdata", bus.data_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Even start, known pattern
        start_xfer(8'h02, 1'b0);
        wait_done();
        check_xfer("even", 8'h02, 1'b0);
        if (wr_q.size() == 256) begin
            chk("even_first_byte", wr_q[0], 8'h5A);
            chk("even_last_byte", wr_q[255], 8'hA5);
        end

        // Odd start
        start_xfer(8'h02, 1'b1);
        wait_done();
        check_xfer("odd", 8'h02, 1'b1);

        // Page FF stays inside FF00..FFFF
        start_xfer(8'hFF, 1'b0);
        wait_done();
        check_xfer("pageff", 8'hFF, 1'b0);
        if (wr_q.size() == 256) chk("pageff_last", wr_q[255], mem[16'hFFFF]);

        // Retrigger while busy is ignored
        start_xfer(8'h02, 1'b0);
        wait_writes(50);
        @(posedge clk);
        #1 trigger = 1'b1; page = 8'h03;
        @(posedge clk);
        #1 trigger = 1'b0;
        wait_done();
        check_xfer("retrig", 8'h02, 1'b0);
`ifdef OAM_DMA_STATS_EN
        chk("retrig_ignored_count", ignored_count, 1);
        chk("retrig_xfer_count", xfer_count, 4);
`endif
        repeat (3) @(negedge clk);
        #1 chk("retrig_no_restart", stall, 0);

        // Reset during the write of byte 100
        start_xfer(8'h02, 1'b0);
        wait_writes(101);
        chk("midrst_in_write", bus.wen, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wen", bus.wen, 0);
        chk("midrst_stall", stall, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", stall, 0);
        start_xfer(8'h02, 1'b0);
        wait_done();
        check_xfer("after_rst", 8'h02, 1'b0);
        if (rd_q.size() > 0) chk("after_rst_first_read", rd_q[0], 16'h0200);

        // Back-to-back: trigger in the done cycle
        do_reset();
        start_xfer(8'h04, 1'b0);
        wait_done();
        check_xfer("b2b_first", 8'h04, 1'b0);
        clear_mon();
        trigger = 1'b1; page = 8'h05;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        #1 chk("b2b_halt_next", stall, 1);
        wait_done();
        check_xfer("b2b_second", 8'h05, 1'b0);
`ifdef OAM_DMA_STATS_EN
        chk("b2b_xfer_count", xfer_count, 2);
        chk("b2b_ignored_count", ignored_count, 0);
`endif

        // Randomized pages and start parity
        for (int r = 0; r < 4; r++) begin
            pg = 8'($urandom_range(1, 255));
            if (pg == 8'h20) pg = 8'h21;
            odd = 1'($urandom);
            start_xfer(pg, odd);
            wait_done();
            check_xfer("rand", pg, odd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global runaway guard.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
